// File: rtl/signal_conditioner.sv
// signal_conditioner: pad synchroniser, glitch filter and edge pulser feeding the frequency counter.
// Latency: signal_in -> signal_out in 2 + filt_len + 1 clk edges, edge_pulse registered on that same edge.
// No backpressure; define SIGCOND_PRESCALE_EN to emit one pulse per prescale+1 qualified edges.
module signal_conditioner #(
   parameter int FILT_W   = 4,
   parameter int GLITCH_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                signal_in,
   input  logic [FILT_W-1:0]   filt_len,
   input  logic [1:0]          edge_sel,
   input  logic [3:0]          prescale,
   output logic                signal_out,
   output logic                edge_pulse,
   output logic [GLITCH_W-1:0] glitch_count
);

   localparam logic [FILT_W-1:0]   STAB_ONE   = 1;
   localparam logic [GLITCH_W-1:0] GLITCH_ONE = 1;

   logic              r_s0;
   logic              r_s1;
   logic [FILT_W-1:0] r_stab;
   logic              w_qual;

   // The accepted level is always r_s1, so qualification only needs r_s1.
   always_comb begin
      w_qual = 1'b0;
      case (edge_sel)
         2'b00:   w_qual = r_s1;
         2'b01:   w_qual = ~r_s1;
         2'b10:   w_qual = 1'b1;
         default: w_qual = 1'b0;
      endcase
   end

`ifdef SIGCOND_PRESCALE_EN
   logic [3:0] r_pre;
`else
   logic w_unused_prescale;
   assign w_unused_prescale = ^prescale;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s0         <= 1'b0;
         r_s1         <= 1'b0;
         r_stab       <= '0;
         signal_out   <= 1'b0;
         edge_pulse   <= 1'b0;
         glitch_count <= '0;
`ifdef SIGCOND_PRESCALE_EN
         r_pre        <= '0;
`endif
      end else begin
         r_s0       <= signal_in;
         r_s1       <= r_s0;
         edge_pulse <= 1'b0;
         if (r_s1 != signal_out) begin
            // Live filt_len compare: a lowered threshold accepts on the next disagreeing cycle.
            if (r_stab >= filt_len) begin
               signal_out <= r_s1;
               r_stab     <= '0;
               if (w_qual) begin
`ifdef SIGCOND_PRESCALE_EN
                  if (r_pre >= prescale) begin
                     edge_pulse <= 1'b1;
                     r_pre      <= '0;
                  end else begin
                     r_pre <= r_pre + 4'd1;
                  end
`else
                  edge_pulse <= 1'b1;
`endif
               end
            end else begin
               r_stab <= r_stab + STAB_ONE;
            end
         end else if (r_stab != '0) begin
            r_stab <= '0;
            if (glitch_count != '1) begin
               glitch_count <= glitch_count + GLITCH_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_signal_conditioner.sv
// Scoreboarded bench for signal_conditioner: directed scenarios plus randomized input runs.
module tb_signal_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic       signal_in;
   logic [3:0] filt_len;
   logic [1:0] edge_sel;
   logic [3:0] prescale;
   logic       signal_out;
   logic       edge_pulse;
   logic [7:0] glitch_count;

   signal_conditioner #(.FILT_W(4), .GLITCH_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .signal_in    (signal_in),
      .filt_len     (filt_len),
      .edge_sel     (edge_sel),
      .prescale     (prescale),
      .signal_out   (signal_out),
      .edge_pulse   (edge_pulse),
      .glitch_count (glitch_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       o;
      logic       p;
      logic [7:0] g;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_pulse = 0;
   int   n_tog = 0;
   int   sq_ph = 0;

   // Reference model: input history queue, disagreement run length, edge tally.
   bit   m_hist[$];
   bit   m_out;
   bit   m_pulse;
   int   m_run;
   int   m_gc;
   int   m_edges;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic step();
      bit d;
      bit q;
      @(posedge clk);
      if (reset) begin
         m_hist  = '{1'b0, 1'b0};
         m_out   = 1'b0;
         m_pulse = 1'b0;
         m_run   = 0;
         m_gc    = 0;
         m_edges = 0;
      end else begin
         d = m_hist.pop_front();
         m_hist.push_back(signal_in);
         m_pulse = 1'b0;
         if (d != m_out) begin
            m_run++;
            if (m_run >= int'(filt_len) + 1) begin
               m_out = d;
               m_run = 0;
               q = (edge_sel == 2'b10) || (edge_sel == 2'b00 && d) || (edge_sel == 2'b01 && !d);
               if (q) begin
`ifdef SIGCOND_PRESCALE_EN
                  if (m_edges >= int'(prescale)) begin
                     m_pulse = 1'b1;
                     m_edges = 0;
                  end else begin
                     m_edges++;
                  end
`else
                  m_pulse = 1'b1;
`endif
               end
            end
         end else if (m_run > 0) begin
            m_run = 0;
            if (m_gc < 255) m_gc++;
         end
      end
      exp_q.push_back('{m_out, m_pulse, 8'(m_gc)});
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      signal_in = v;
      repeat (n) step();
   endtask

   task automatic square(input int n);
      for (int i = 0; i < n; i++) begin
         signal_in = ((sq_ph % 8) < 4);
         sq_ph++;
         step();
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Monitor: one expected response per clock, compared away from the active edge.
   initial begin
      exp_t e;
      logic prev_o;
      prev_o = 1'b0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle_out_pulse_gc", {22'd0, signal_out, edge_pulse, glitch_count}, {22'd0, e});
            if (edge_pulse === 1'b1) n_pulse++;
            if (signal_out !== prev_o) n_tog++;
            prev_o = signal_out;
         end
      end
   end

   initial begin
      int snap;
      int tsnap;
      reset     = 1'b1;
      signal_in = 1'b1;
      filt_len  = 4'd0;
      edge_sel  = 2'b00;
      prescale  = 4'd0;

      // Reset with a high input, then first accepted rising edge on the 3rd edge.
      repeat (3) step();
      chk("rst_out", {31'd0, signal_out}, 32'd0);
      chk("rst_pulse", {31'd0, edge_pulse}, 32'd0);
      chk("rst_gc", {24'd0, glitch_count}, 32'd0);
      reset = 1'b0;
      step();
      step();
      chk("rise_not_before_3rd", {31'd0, signal_out}, 32'd0);
      step();
      chk("rise_on_3rd", {31'd0, signal_out}, 32'd1);
      chk("pulse_on_3rd", {31'd0, edge_pulse}, 32'd1);
      step();
      chk("pulse_one_cycle", {31'd0, edge_pulse}, 32'd0);

      // Short pulse rejected as a glitch at filt_len=4.
      hold(1'b0, 4);
      chk("fall_fl0", {31'd0, signal_out}, 32'd0);
      filt_len = 4'd4;
      settle();
      snap = n_pulse;
      hold(1'b1, 3);
      hold(1'b0, 10);
      settle();
      chk("glitch_out", {31'd0, signal_out}, 32'd0);
      chk("glitch_cnt1", {24'd0, glitch_count}, 32'd1);
      chk("glitch_nopulse", n_pulse - snap, 32'd0);

      // Pulse of exactly filt_len+1 cycles accepted 7 edges after the input rises.
      hold(1'b1, 5);
      signal_in = 1'b0;
      step();
      chk("fl4_not_edge6", {31'd0, signal_out}, 32'd0);
      step();
      chk("fl4_rise_edge7", {31'd0, signal_out}, 32'd1);
      chk("fl4_pulse_edge7", {31'd0, edge_pulse}, 32'd1);
      hold(1'b0, 10);
      chk("fl4_fall", {31'd0, signal_out}, 32'd0);
      chk("fl4_gc_still1", {24'd0, glitch_count}, 32'd1);

      // Both-edge mode on a period-8 square wave, then edge_sel=none.
      filt_len = 4'd0;
      edge_sel = 2'b10;
      square(8);
      settle();
      snap = n_pulse;
      square(64);
      settle();
      chk("both_pulses_64cyc", n_pulse - snap, 32'd16);
      edge_sel = 2'b11;
      snap  = n_pulse;
      tsnap = n_tog;
      square(32);
      settle();
      chk("none_pulses", n_pulse - snap, 32'd0);
      chk("none_toggles", n_tog - tsnap, 32'd8);

      // Glitch counter saturation.
      edge_sel = 2'b00;
      filt_len = 4'd2;
      hold(1'b0, 10);
      settle();
      snap = n_pulse;
      repeat (300) begin
         hold(1'b1, 2);
         hold(1'b0, 10);
      end
      settle();
      chk("gc_saturated", {24'd0, glitch_count}, 32'd255);
      chk("gc_sat_out", {31'd0, signal_out}, 32'd0);
      chk("gc_sat_nopulse", n_pulse - snap, 32'd0);

      // Randomized runs, including live filt_len changes and reset mid-operation.
      repeat (300) begin
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 2)) step();
            reset = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) filt_len = 4'($urandom_range(0, 6));
         if ($urandom_range(0, 5) == 0) edge_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) prescale = 4'($urandom_range(0, 3));
         hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
      end

`ifdef SIGCOND_PRESCALE_EN
      // Prescale by 4 over 12 rising edges, then reset restarting the tally.
      reset = 1'b1;
      step();
      step();
      reset    = 1'b0;
      filt_len = 4'd0;
      edge_sel = 2'b00;
      prescale = 4'd3;
      hold(1'b0, 4);
      settle();
      snap = n_pulse;
      repeat (12) begin
         hold(1'b1, 4);
         hold(1'b0, 4);
      end
      settle();
      chk("pre_12_edges", n_pulse - snap, 32'd3);
      snap = n_pulse;
      repeat (2) begin
         hold(1'b1, 4);
         hold(1'b0, 4);
      end
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      hold(1'b0, 4);
      repeat (3) begin
         hold(1'b1, 4);
         hold(1'b0, 4);
      end
      settle();
      chk("pre_rst_3_edges", n_pulse - snap, 32'd0);
      hold(1'b1, 4);
      hold(1'b0, 4);
      settle();
      chk("pre_rst_4th_edge", n_pulse - snap, 32'd1);
`endif

      settle();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
